// File: rtl/button_debounce_if.sv
// Button bundle between the raw pin side and the debounced event consumers.
// The master drives the raw pins; the slave (the debouncer) drives the clean levels and pulses.
interface button_debounce_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button front end: polarity fix, two-flop synchroniser, and one debounce FSM per button
// producing a clean level plus registered press / release / long-press pulses.
module button_debounce #(
    parameter int N_BTN       = 4,
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 50000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    button_debounce_if.slave   bus
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_PRE = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_HELD      = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    logic [N_BTN-1:0] act_s;
    logic [N_BTN-1:0] s1_r;
    logic [N_BTN-1:0] s2_r;
    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] release_s;
    logic [N_BTN-1:0] long_s;

    assign act_s = bus.btn_raw ^ {N_BTN{(ACTIVE_LOW != 0)}};

    // Two-flop synchroniser on the polarity-corrected pins
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {N_BTN{1'b0}};
            s2_r <= {N_BTN{1'b0}};
        end else begin
            s1_r <= act_s;
            s2_r <= s1_r;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t        state_r;
        state_t        state_nxt_s;
        logic [DW-1:0] dcnt_r;
        logic [DW-1:0] dcnt_nxt_s;
        logic [HW-1:0] hcnt_r;
        logic [HW-1:0] hcnt_nxt_s;
        logic          level_r;
        logic          level_nxt_s;
        logic          press_r;
        logic          press_nxt_s;
        logic          release_r;
        logic          release_nxt_s;
        logic          long_r;
        logic          long_nxt_s;
        logic          held_s;

        // Next-state, counters and pulse decode for one button
        always_comb begin
            state_nxt_s   = state_r;
            dcnt_nxt_s    = dcnt_r;
            hcnt_nxt_s    = hcnt_r;
            level_nxt_s   = level_r;
            press_nxt_s   = 1'b0;
            release_nxt_s = 1'b0;
            held_s        = (state_r == ST_HELD) || (state_r == ST_RELEASING);

            // Hold time keeps running through release bounces and saturates at the limit
            if (held_s && (hcnt_r != LONG_MAX)) begin
                hcnt_nxt_s = hcnt_r + HW'(1);
            end else begin
                hcnt_nxt_s = hcnt_r;
            end
            long_nxt_s = held_s && (hcnt_r == LONG_PRE);

            case (state_r)
                ST_IDLE: begin
                    if (s2_r[i]) begin
                        state_nxt_s = ST_ARMING;
                        dcnt_nxt_s  = DW'(1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMING: begin
                    if (!s2_r[i]) begin
                        state_nxt_s = ST_IDLE;
                        dcnt_nxt_s  = {DW{1'b0}};
                    end else if (dcnt_r == DEB_LAST) begin
                        state_nxt_s = ST_HELD;
                        level_nxt_s = 1'b1;
                        press_nxt_s = 1'b1;
                        dcnt_nxt_s  = {DW{1'b0}};
                        hcnt_nxt_s  = {HW{1'b0}};
                    end else begin
                        dcnt_nxt_s  = dcnt_r + DW'(1);
                    end
                end
                ST_HELD: begin
                    if (!s2_r[i]) begin
                        state_nxt_s = ST_RELEASING;
                        dcnt_nxt_s  = DW'(1);
                    end else begin
                        state_nxt_s = ST_HELD;
                    end
                end
                ST_RELEASING: begin
                    if (s2_r[i]) begin
                        state_nxt_s = ST_HELD;
                        dcnt_nxt_s  = {DW{1'b0}};
                    end else if (dcnt_r == DEB_LAST) begin
                        state_nxt_s   = ST_IDLE;
                        level_nxt_s   = 1'b0;
                        release_nxt_s = 1'b1;
                        dcnt_nxt_s    = {DW{1'b0}};
                    end else begin
                        dcnt_nxt_s    = dcnt_r + DW'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    dcnt_nxt_s  = {DW{1'b0}};
                    level_nxt_s = 1'b0;
                end
            endcase
        end

        // State, counters and registered outputs for one button
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r   <= ST_IDLE;
                dcnt_r    <= {DW{1'b0}};
                hcnt_r    <= {HW{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                state_r   <= state_nxt_s;
                dcnt_r    <= dcnt_nxt_s;
                hcnt_r    <= hcnt_nxt_s;
                level_r   <= level_nxt_s;
                press_r   <= press_nxt_s;
                release_r <= release_nxt_s;
                long_r    <= long_nxt_s;
            end
        end

        assign level_s[i]   = level_r;
        assign press_s[i]   = press_r;
        assign release_s[i] = release_r;
        assign long_s[i]    = long_r;
    end

    assign bus.btn_level   = level_s;
    assign bus.btn_press   = press_s;
    assign bus.btn_release = release_s;
    assign bus.btn_long    = long_s;

endmodule

// File: doc/button_debounce.md
# button_debounce

Front-end conditioning stage for the board push-buttons. It synchronises N raw button inputs into `clk`, debounces each one with an independent per-button state machine, and produces clean levels plus one-cycle press, release and long-press pulses. `btn_level[0]` drives the `enter_key` input of the polled button device. That device registers one event per full press/release cycle, taken on the falling edge of `btn_level[0]`, which is the debounced release.

## Interface
- `N_BTN`, 4: number of independent buttons.
- `DEB_CYCLES`, 500000: consecutive stable cycles needed to accept a change (10 ms at 50 MHz). Must be ≥ 2.
- `LONG_CYCLES`, 50000000: cycles a press must be held before `btn_long` fires. Must be ≥ 1.
- `ACTIVE_LOW`, 1: 1 means a raw input of 0 is "pressed".
- `clk` input 1: system clock.
- `rst` input 1: reset; one clock; reset is synchronous and active-high.
- `btn_raw` input N_BTN: asynchronous raw button pins.
- `btn_level` output N_BTN: debounced level, active-high (1 = pressed).
- `btn_press` output N_BTN: one-cycle pulse when a press is accepted.
- `btn_release` output N_BTN: one-cycle pulse when a release is accepted.
- `btn_long` output N_BTN: one-cycle pulse, at most once per press, after the hold time.

## Operation
- **Polarity:** `act[i] = btn_raw[i] ^ ACTIVE_LOW`. Every later stage works on `act`.
- **Synchroniser:** two flip-flops per bit, `s1 <= act`, `s2 <= s1`. The FSM sees only `s2`.
- **Per-button FSM:** states IDLE, ARMING, HELD, RELEASING. Each button has a debounce counter `dcnt` of width clog2(DEB_CYCLES).
  - IDLE: if `s2`=1, go to ARMING with `dcnt`<=1. Otherwise stay.
  - ARMING, `s2`=0: go to IDLE with `dcnt`<=0.
  - ARMING, `s2`=1 and `dcnt`==DEB_CYCLES-1: go to HELD with `btn_level`<=1, `btn_press` pulse, `dcnt`<=0, `hcnt`<=0.
  - ARMING, `s2`=1 otherwise: `dcnt`++.
  - HELD: if `s2`=0, go to RELEASING with `dcnt`<=1.
  - RELEASING, `s2`=1: return to HELD with `dcnt`<=0. Produce no pulses.
  - RELEASING, `s2`=0 and `dcnt`==DEB_CYCLES-1: go to IDLE with `btn_level`<=0, `btn_release` pulse.
  - RELEASING, `s2`=0 otherwise: `dcnt`++.
- **Long press:**
  - Hold counter `hcnt` has width clog2(LONG_CYCLES+1).
  - It increments in HELD and RELEASING and saturates at LONG_CYCLES.
  - `btn_long` pulses in the cycle `hcnt` steps from LONG_CYCLES-1 to LONG_CYCLES.
  - A bounce back to HELD does not clear `hcnt`. It is cleared only on entry to HELD from ARMING.
- **Independence:** buttons share no state. Simultaneous events on different bits are all reported in the same cycle.
- **Pulses:** all pulses are registered and last exactly one cycle.
  - `btn_press` and `btn_release` never coincide on one bit.
  - `btn_long` may coincide with the release pulse only if the timing lands on the same edge.

## Timing
- **Reset values:**
  - Outputs: `btn_level`, `btn_press`, `btn_release`, `btn_long` are all 0 on the edge after `rst` is sampled high.
  - Internal state: FSMs go to IDLE, and `dcnt`, `hcnt`, `s1` and `s2` are cleared to 0 (inactive).
- **Press latency:** raw change set up before edge 0. `s2` is valid after edge 1. `btn_level` rises and `btn_press` pulses after edge DEB_CYCLES+1, i.e. visible in cycle DEB_CYCLES+2.
- **Release latency:** the same, DEB_CYCLES+2 edges.
- **Long latency:** `btn_long` pulses exactly LONG_CYCLES cycles after the `btn_press` cycle, provided the button is not released first.
- **Glitch rejection:** an active pulse shorter than DEB_CYCLES synchronised cycles never changes `btn_level`.
- **Reset mid-operation:** the button returns to IDLE immediately and no `btn_release` is emitted.
  - If the button is still held after reset, a full debounce runs again and produces a new `btn_press`.
- **Throughput:** a button can complete a full press/release cycle in 2·DEB_CYCLES synchronised cycles.

## Test plan
Benches use N_BTN=4, DEB_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
1. Assert `rst` for 2 cycles with `btn_raw`=4'hF -> all outputs 0. They stay 0 for 50 cycles.
2. Drive `btn_raw[0]` to 0 at edge 0 and hold -> `btn_level[0]` goes 1 and `btn_press[0]` pulses once after edge 5. `btn_long[0]` pulses once 20 cycles later and never again.
3. Pulse `btn_raw[1]` low for 3 cycles, high for 1, low for 3 -> no activity on any output bit 1.
4. With button 2 held, drop the input for 2 cycles, then restore -> no `btn_release[2]`. `btn_level[2]` stays 1 and `btn_long[2]` fires on the original schedule.
5. Press buttons 0 and 3 on the same edge -> `btn_press` equals 4'b1001 in a single cycle. Releasing both together gives `btn_release`=4'b1001 in one cycle.
6. Assert `rst` while button 0 is in HELD and keep the raw input pressed -> no release pulse. After reset deasserts, `btn_press[0]` pulses again after DEB_CYCLES+2 edges.
